// File: rtl/serial_alu_if.sv
// Start/done request bus of the bit-serial ALU sequencer.
interface serial_alu_if #(parameter int WIDTH = 64);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  modport master (output start, a, b, alu_op,
                  input  busy, done, result, zero, carry_out, overflow);
  modport slave  (input  start, a, b, alu_op,
                  output busy, done, result, zero, carry_out, overflow);
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one bit per clock through a 1-bit slice, LSB first, carry held in a flop.
module serial_alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  serial_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [3:0]       op;
  logic [CW-1:0]    count;
  logic             carry;

  logic             ai, bi, rbit, ncarry;
  logic [WIDTH-1:0] nres;

  always_comb begin
    ai     = a_sh[0] ^ op[3];
    bi     = b_sh[0] ^ op[2];
    ncarry = (ai & bi) | (ai & carry) | (bi & carry);
    if (op[1])      rbit = ai ^ bi ^ carry;
    else if (op[0]) rbit = ai | bi;
    else            rbit = ai & bi;
    nres = {rbit, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      res_sh        <= '0;
      op            <= '0;
      count         <= '0;
      carry         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sh     <= bus.a;
          b_sh     <= bus.b;
          op       <= bus.alu_op;
          count    <= '0;
          // Binvert doubles as carry-in so 0110 computes a + ~b + 1
          carry    <= bus.alu_op[2];
          state    <= RUN;
          bus.busy <= 1'b1;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= nres;
          carry  <= ncarry;
          count  <= count + 1'b1;
          if (count == CW'(WIDTH-1)) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.result    <= nres;
            bus.zero      <= (nres == '0);
            bus.carry_out <= ncarry;
            // carry currently held is the carry into the MSB
            bus.overflow  <= carry ^ ncarry;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq at WIDTH=8 and WIDTH=64.
module tb_serial_alu_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_alu_if #(.WIDTH(8))  bus8 ();
  serial_alu_if #(.WIDTH(64)) bus64 ();

  serial_alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
  serial_alu_seq #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          w;
    logic [63:0] a, b;
    logic [3:0]  op;
    logic [63:0] res;
    logic        z, c, v;
    logic        chk_cv;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] op);
    if (w == 8) begin
      bus8.start = s; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.alu_op = op;
    end else begin
      bus64.start = s; bus64.a = a; bus64.b = b; bus64.alu_op = op;
    end
  endtask

  task automatic sample(input int w, output logic d, output logic bsy, output logic [63:0] r,
                        output logic z, output logic c, output logic v);
    if (w == 8) begin
      d = bus8.done; bsy = bus8.busy; r = {56'd0, bus8.result};
      z = bus8.zero; c = bus8.carry_out; v = bus8.overflow;
    end else begin
      d = bus64.done; bsy = bus64.busy; r = bus64.result;
      z = bus64.zero; c = bus64.carry_out; v = bus64.overflow;
    end
  endtask

  task automatic run_vec(input vec_t t, input string name);
    logic d, bsy, z, c, v;
    logic [63:0] r;
    int lat;
    @(negedge clk);
    drive(t.w, 1'b1, t.a, t.b, t.op);
    lat = 0;
    d = 1'b0;
    while (!d && lat < 200) begin
      @(negedge clk);
      drive(t.w, 1'b0, 64'd0, 64'd0, 4'd0);
      lat++;
      sample(t.w, d, bsy, r, z, c, v);
      if (lat == 1) check({name, " busy"}, {63'd0, bsy}, 64'd1);
    end
    check({name, " latency"}, 64'(lat), 64'(t.w + 1));
    check({name, " result"}, r, t.res);
    check({name, " zero"}, {63'd0, z}, {63'd0, t.z});
    if (t.chk_cv) begin
      check({name, " carry"}, {63'd0, c}, {63'd0, t.c});
      check({name, " ovf"}, {63'd0, v}, {63'd0, t.v});
    end
    @(negedge clk);
    sample(t.w, d, bsy, r, z, c, v);
    check({name, " done pulse"}, {63'd0, d}, 64'd0);
  endtask

  localparam logic [63:0] A64 = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [63:0] B64 = 64'hFF00_0000_0000_0000;

  vec_t vecs[12];

  initial begin
    logic d, bsy, z, c, v;
    logic [63:0] r;
    int t_done1, t_done2, cyc;
    logic stable;

    vecs[0]  = '{8,  64'h05, 64'h03, 4'b0010, 64'h08, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8,  64'h03, 64'h03, 4'b0110, 64'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{8,  64'h7F, 64'h01, 4'b0010, 64'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{8,  64'hFF, 64'h01, 4'b0010, 64'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{8,  64'h80, 64'h01, 4'b0110, 64'h7F, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{8,  64'h80, 64'h80, 4'b0010, 64'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{8,  64'hCC, 64'hAA, 4'b0000, 64'h88, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8,  64'h0F, 64'hF0, 4'b1100, 64'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{64, A64, B64, 4'b0000, 64'hF000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{64, A64, B64, 4'b0001, 64'hFFF0_F0F0_F0F0_F0F0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{64, A64, B64, 4'b1100, 64'h000F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{64, 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    drive(8, 1'b0, 64'd0, 64'd0, 4'd0);
    drive(64, 1'b0, 64'd0, 64'd0, 4'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sample(8, d, bsy, r, z, c, v);
    check("rst8 busy/done", {62'd0, bsy, d}, 64'd0);
    check("rst8 result", r, 64'd0);
    check("rst8 flags", {61'd0, z, c, v}, 64'd0);
    sample(64, d, bsy, r, z, c, v);
    check("rst64 outputs", r | {60'd0, bsy, d, z, c|v}, 64'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset during the 4th RUN cycle aborts without a done pulse
    @(negedge clk);
    drive(8, 1'b1, 64'h12, 64'h34, 4'b0010);
    @(negedge clk);
    drive(8, 1'b0, 64'd0, 64'd0, 4'd0);
    repeat (3) @(negedge clk);
    sample(8, d, bsy, r, z, c, v);
    check("abort pre busy", {63'd0, bsy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sample(8, d, bsy, r, z, c, v);
    check("abort busy/done", {62'd0, bsy, d}, 64'd0);
    check("abort result", r, 64'd0);
    check("abort flags", {61'd0, z, c, v}, 64'd0);
    stable = 1'b1;
    repeat (12) begin
      @(negedge clk);
      sample(8, d, bsy, r, z, c, v);
      if (d || bsy) stable = 1'b0;
    end
    check("abort no done", {63'd0, stable}, 64'd1);
    run_vec('{8, 64'h12, 64'h34, 4'b0010, 64'h46, 1'b0, 1'b0, 1'b0, 1'b1}, "post-abort");

    // start held high: back-to-back ops every WIDTH+2 cycles, result held between dones
    @(negedge clk);
    drive(8, 1'b1, 64'h01, 64'h02, 4'b0010);
    t_done1 = -1; t_done2 = -1; stable = 1'b1;
    for (cyc = 1; cyc < 60 && t_done2 < 0; cyc++) begin
      @(negedge clk);
      sample(8, d, bsy, r, z, c, v);
      if (d && t_done1 < 0) begin
        t_done1 = cyc;
        check("stream first result", r, 64'h03);
        drive(8, 1'b1, 64'h04, 64'h04, 4'b0010);
      end else if (d) begin
        t_done2 = cyc;
        check("stream second result", r, 64'h08);
      end else if (t_done1 >= 0 && r != 64'h03) begin
        stable = 1'b0;
      end
    end
    drive(8, 1'b0, 64'd0, 64'd0, 4'd0);
    check("stream first latency", 64'(t_done1), 64'd9);
    check("stream interval", 64'(t_done2 - t_done1), 64'd10);
    check("stream result hold", {63'd0, stable}, 64'd1);
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
